// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the event counter.
// Latency: n/a (package only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // True when a decade is at its top value and the next increment wraps it.
  function automatic logic bcd_is_max(input logic [BCD_W-1:0] digit);
    return digit == BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 on inc_in and forwards the carry to the next decade.
// Latency: digit updates one clock after inc_in; inc_out is combinational.
// Backpressure: none; hold freezes the decade (used to saturate the whole chain).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_in,
  input  logic             hold,
  output logic [BCD_W-1:0] digit,
  output logic             at_max,
  output logic             inc_out
);

  assign at_max  = bcd_is_max(digit);
  assign inc_out = inc_in & at_max;

  // Decade register: clear wins, otherwise step 0..9 and wrap to 0 after 9.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (inc_in && !hold) begin
      digit <= at_max ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Counts rising edges of tick_in into a packed multi-decade BCD value with snapshot/overflow.
// Latency: count, overflow and carry_out update one clock after the edge that sees the tick rise.
// Backpressure: none; ticks arriving while enable=0 or clear=1 are dropped, not queued.
module bcd_event_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_in,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    latch,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic [BCD_W*DIGITS-1:0] snapshot,
  output logic                    overflow,
  output logic                    carry_out
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic              tick_q;
  logic              inc;
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] at_max_v;
  logic              all_max;
  logic              hold;
  logic              roll;

  assign inc      = tick_in & ~tick_q & enable;
  assign chain[0] = inc;
  assign all_max  = &at_max_v;
  // Saturating mode freezes every decade once the whole count reads all-9s.
  assign hold     = ~WRAP_EN & all_max;
  // The carry out of the top decade is exactly "increment while all-9s".
  assign roll     = chain[DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .inc_in  (chain[gi]),
        .hold    (hold),
        .digit   (count[BCD_W*gi +: BCD_W]),
        .at_max  (at_max_v[gi]),
        .inc_out (chain[gi+1])
      );
    end
  endgenerate

  // Edge detector history; tracks tick_in regardless of enable/clear so a held tick counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  // Sticky overflow and single-cycle rollover pulse; clear beats a coincident rollover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      overflow  <= overflow | roll;
      carry_out <= roll & WRAP_EN;
    end
  end

  // Snapshot captures the pre-update count, independent of enable and clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot <= '0;
    end else if (latch) begin
      snapshot <= count;
    end
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Bench for bcd_event_counter: a wrapping and a saturating instance share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_event_counter;

  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_in = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        latch = 1'b0;
  logic [15:0] count1, snapshot1, count0, snapshot0;
  logic        overflow1, carry1, overflow0, carry0;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;
  int carry_cnt1 = 0;
  int carry_cnt0 = 0;

  // Model state: plain integer counts per instance.
  int m_val1, m_val0, m_snap1, m_snap0;
  bit m_ovf1, m_ovf0, m_car1, m_car0, m_prev;

  always #5 clk = ~clk;

  bcd_event_counter #(.DIGITS(4), .WRAP(1)) dut_wrap (
    .clk(clk), .reset(reset), .tick_in(tick_in), .enable(enable), .clear(clear),
    .latch(latch), .count(count1), .snapshot(snapshot1), .overflow(overflow1),
    .carry_out(carry1)
  );

  bcd_event_counter #(.DIGITS(4), .WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .tick_in(tick_in), .enable(enable), .clear(clear),
    .latch(latch), .count(count0), .snapshot(snapshot0), .overflow(overflow0),
    .carry_out(carry0)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer count with wrap/saturate rules applied on each clock.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val1 = 0; m_val0 = 0; m_snap1 = 0; m_snap0 = 0;
      m_ovf1 = 0; m_ovf0 = 0; m_car1 = 0; m_car0 = 0; m_prev = 0;
    end else begin
      bit inc;
      inc = tick_in && !m_prev && enable;
      if (latch) begin
        m_snap1 = m_val1;
        m_snap0 = m_val0;
      end
      m_car1 = 0;
      m_car0 = 0;
      if (clear) begin
        m_val1 = 0; m_val0 = 0; m_ovf1 = 0; m_ovf0 = 0;
      end else if (inc) begin
        if (m_val1 == MAXV) begin
          m_val1 = 0; m_ovf1 = 1; m_car1 = 1;
        end else begin
          m_val1 = m_val1 + 1;
        end
        if (m_val0 == MAXV) m_ovf0 = 1;
        else m_val0 = m_val0 + 1;
      end
      m_prev = tick_in;
    end
  end

  // Per-cycle compare against the model, after the edge has settled.
  always @(posedge clk) begin
    #2;
    if (checking) begin
      chk("cyc_count_w", count1, to_bcd(m_val1));
      chk("cyc_snap_w", snapshot1, to_bcd(m_snap1));
      chk("cyc_ovf_w", 16'(overflow1), 16'(m_ovf1));
      chk("cyc_carry_w", 16'(carry1), 16'(m_car1));
      chk("cyc_count_s", count0, to_bcd(m_val0));
      chk("cyc_snap_s", snapshot0, to_bcd(m_snap0));
      chk("cyc_ovf_s", 16'(overflow0), 16'(m_ovf0));
      chk("cyc_carry_s", 16'(carry0), 16'(m_car0));
      if (carry1 === 1'b1) carry_cnt1++;
      if (carry0 === 1'b1) carry_cnt0++;
    end
  end

  task automatic pulse();
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) tick_in = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) pulse();
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_count", count1, 16'h0000);
    chk("rst_snap", snapshot1, 16'h0000);
    chk("rst_ovf", 16'(overflow1), 16'h0);
    chk("rst_carry", 16'(carry1), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;

    // 1: twelve clean pulses
    pulses(12);
    chk("t1_count", count1, 16'h0012);
    chk("t1_ovf", 16'(overflow1), 16'h0);
    chk("t1_carry_cnt", 16'(carry_cnt1), 16'h0);

    // 2: tick held high five cycles counts once
    @(negedge clk) tick_in = 1'b1;
    repeat (5) @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    chk("t2_held", count1, 16'h0013);

    // 5: latch/clear interactions and enable gating
    do_clear();
    chk("t5_clr", count1, 16'h0000);
    pulses(41);
    chk("t5_41", count1, 16'h0041);
    @(negedge clk) begin latch = 1'b1; tick_in = 1'b1; end
    @(negedge clk) begin latch = 1'b0; tick_in = 1'b0; end
    chk("t5_latch_snap", snapshot1, 16'h0041);
    chk("t5_latch_cnt", count1, 16'h0042);
    @(negedge clk) begin clear = 1'b1; tick_in = 1'b1; end
    @(negedge clk) clear = 1'b0;
    @(negedge clk) tick_in = 1'b0;
    @(negedge clk);
    chk("t5_clr_tick", count1, 16'h0000);
    chk("t5_clr_ovf", 16'(overflow1), 16'h0);
    enable = 1'b0;
    pulses(4);
    chk("t5_disabled", count1, 16'h0000);
    enable = 1'b1;

    // 6: asynchronous reset mid-cycle
    pulses(123);
    @(negedge clk) latch = 1'b1;
    @(negedge clk) latch = 1'b0;
    chk("t6_pre", count1, 16'h0123);
    chk("t6_pre_snap", snapshot1, 16'h0123);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6_async_cnt", count1, 16'h0000);
    chk("t6_async_snap", snapshot1, 16'h0000);
    chk("t6_async_ovf", 16'(overflow1), 16'h0);
    chk("t6_async_car", 16'(carry1), 16'h0);
    tick_in = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) tick_in = 1'b0;
    chk("t6_after_rel", count1, 16'h0001);

    // 3/4: rollover versus saturation
    do_clear();
    pulses(9999);
    chk("t3_9999_w", count1, 16'h9999);
    chk("t4_9999_s", count0, 16'h9999);
    chk("t3_pre_ovf", 16'(overflow1), 16'h0);
    carry_cnt1 = 0;
    carry_cnt0 = 0;
    pulse();
    @(negedge clk);
    chk("t3_wrap_cnt", count1, 16'h0000);
    chk("t3_wrap_ovf", 16'(overflow1), 16'h1);
    chk("t3_carry_once", 16'(carry_cnt1), 16'h1);
    chk("t4_sat_cnt", count0, 16'h9999);
    pulse();
    chk("t3_next", count1, 16'h0001);
    chk("t3_ovf_sticky", 16'(overflow1), 16'h1);
    pulses(2);
    chk("t4_sat_hold", count0, 16'h9999);
    chk("t4_sat_ovf", 16'(overflow0), 16'h1);
    chk("t4_sat_carry", 16'(carry_cnt0), 16'h0);
    chk("t3_after3", count1, 16'h0003);

    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
